// File: rtl/mem_pkg.sv
// Shared types and reset constants for the memory stage and its memory-interface controller.
package mem_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_COUT = 2'b11
    } wb_sel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    localparam mem_state_t RST_STATE = ST_IDLE;
    localparam logic [4:0] RST_DEST  = 5'd0;
    localparam logic       RST_FLAG  = 1'b0;

endpackage

// File: rtl/mem_if_ctrl.sv
// IDLE/BUSY handshake controller: latches one memory request, holds it until ack or timeout.
module mem_if_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              we_i,
    input  logic [4:0]        dest_i,
    input  logic              rwe_i,
    input  logic              mem_ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [4:0]        dest_o,
    output logic              rwe_o,
    output logic              mem_err_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic              we_q, rwe_q, err_q;
    logic [4:0]        dest_q;
    logic              busy, timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= RST_STATE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_BUSY;
            ST_BUSY: if (mem_ack_i || cnt_q == LAST_CNT) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_BUSY);
        done_o  = busy && mem_ack_i;
        // ack in the final wait cycle still counts as a completion
        timeout = busy && !mem_ack_i && (cnt_q == LAST_CNT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= RST_FLAG;
            rwe_q   <= RST_FLAG;
            dest_q  <= RST_DEST;
            err_q   <= RST_FLAG;
        end else begin
            err_q <= timeout;
            if (!busy && start_i) begin
                cnt_q   <= '0;
                addr_q  <= {addr_i[DATA_W-1:2], 2'b00};
                wdata_q <= wdata_i;
                we_q    <= we_i;
                rwe_q   <= rwe_i;
                dest_q  <= dest_i;
            end else if (busy) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign busy_o      = busy;
    assign mem_req_o   = busy;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign dest_o      = dest_q;
    assign rwe_o       = rwe_q;
    assign mem_err_o   = err_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: write-back mux, single write-back pipeline register, stall and forwarding taps.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [DATA_W-1:0] read_data2_i,
    input  logic [DATA_W-1:0] cout_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [1:0]        wb_sel_i,
    input  logic              reg_write_enable_i,
    input  logic              mem_write_enable_i,
    input  logic [4:0]        write_reg_sel_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              reg_write_enable_o,
    output logic [4:0]        write_reg_sel_o,
    output logic              valid_o,
    output logic [4:0]        m_dest_reg_o,
    output logic              m_dest_reg_en_o,
    output logic              mem_err_o
);

    logic              mem_op, start, busy, done, held_we, held_rwe;
    logic [4:0]        held_dest;
    logic [DATA_W-1:0] pass_data;

    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              rwe_q, rwe_d, valid_q, valid_d;
    logic [4:0]        sel_q, sel_d;

    assign mem_op = valid_i && (wb_sel_t'(wb_sel_i) == WB_LOAD || mem_write_enable_i);
    assign start  = mem_op && !flush_i;

    mem_if_ctrl #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) u_ctrl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start),
        .addr_i      (result_i),
        .wdata_i     (read_data2_i),
        .we_i        (mem_write_enable_i),
        .dest_i      (write_reg_sel_i),
        .rwe_i       (reg_write_enable_i),
        .mem_ack_i   (mem_ack_i),
        .busy_o      (busy),
        .done_o      (done),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (held_we),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .dest_o      (held_dest),
        .rwe_o       (held_rwe),
        .mem_err_o   (mem_err_o)
    );

    always_comb begin
        case (wb_sel_t'(wb_sel_i))
            WB_PC4:  pass_data = pc_i + DATA_W'(4);
            WB_COUT: pass_data = cout_i;
            default: pass_data = result_i;
        endcase
    end

    // Every path not listed below (capture, wait, timeout, flush, idle) emits a bubble.
    always_comb begin
        wb_data_d = '0;
        rwe_d     = 1'b0;
        sel_d     = RST_DEST;
        valid_d   = 1'b0;
        if (busy) begin
            if (done) begin
                wb_data_d = held_we ? '0 : mem_rdata_i;
                rwe_d     = held_rwe && !held_we;
                sel_d     = held_dest;
                valid_d   = 1'b1;
            end
        end else if (valid_i && !flush_i && !mem_op) begin
            wb_data_d = pass_data;
            rwe_d     = reg_write_enable_i;
            sel_d     = write_reg_sel_i;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_data_q <= '0;
            rwe_q     <= RST_FLAG;
            sel_q     <= RST_DEST;
            valid_q   <= RST_FLAG;
        end else begin
            wb_data_q <= wb_data_d;
            rwe_q     <= rwe_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
        end
    end

    assign mem_we_o           = held_we;
    assign stall_o            = busy;
    assign wb_data_o          = wb_data_q;
    assign reg_write_enable_o = rwe_q;
    assign write_reg_sel_o    = sel_q;
    assign valid_o            = valid_q;
    assign m_dest_reg_o       = sel_q;
    assign m_dest_reg_en_o    = rwe_q && valid_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed corner cases followed by randomized ops against a memory model.
module tb_mem_stage;

    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0, rst = 1'b1;
    logic          valid_i = 1'b0, flush_i = 1'b0;
    logic [DW-1:0] result_i = '0, rd2_i = '0, cout_i = '0, pc_i = '0;
    logic [1:0]    wb_sel_i = '0;
    logic          rwe_i = 1'b0, mwe_i = 1'b0;
    logic [4:0]    rd_i = '0;
    logic          mem_req, mem_we, mem_ack = 1'b0;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic          stall, rwe_o, valid_o, m_en, mem_err;
    logic [DW-1:0] wb_data;
    logic [4:0]    sel_o, m_dest;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .flush_i(flush_i),
        .result_i(result_i), .read_data2_i(rd2_i), .cout_i(cout_i), .pc_i(pc_i),
        .wb_sel_i(wb_sel_i), .reg_write_enable_i(rwe_i), .mem_write_enable_i(mwe_i),
        .write_reg_sel_i(rd_i), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata), .stall_o(stall), .wb_data_o(wb_data),
        .reg_write_enable_o(rwe_o), .write_reg_sel_o(sel_o), .valid_o(valid_o),
        .m_dest_reg_o(m_dest), .m_dest_reg_en_o(m_en), .mem_err_o(mem_err)
    );

    int pass_cnt = 0, tot_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic [31:0] d;
        logic        rwe;
        logic [4:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    int          err_exp = 0;
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] dev_mem[logic [31:0]];
    int          cur_lat = 1;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic        exp_we = 1'b0;
    int          last_stall;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            chk("tap_en", m_en, rwe_o & valid_o);
            chk("tap_dest", m_dest, sel_o);
            chk("stall_eq_req", stall, mem_req);
            if (mem_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_cmd", {mem_we, mem_wdata}, {exp_we, exp_wdata});
            end
            if (valid_o) begin
                chk("valid_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wb_out", {wb_data, rwe_o, sel_o}, {e.d, e.rwe, e.rd});
                end
            end
            if (mem_err) begin
                chk("err_bubble", valid_o, 1'b0);
                chk("err_expected", err_exp > 0, 1'b1);
                if (err_exp > 0) err_exp--;
            end
        end
    end

    // Memory responder: acks after cur_lat request cycles; stray acks when idle
    int bcnt = 0;
    always @(negedge clk) begin
        if (mem_req && !rst) begin
            bcnt++;
            if (bcnt == cur_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : 32'h0;
                if (mem_we) dev_mem[mem_addr] = mem_wdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            bcnt      = 0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    end

    task automatic issue(input logic v, input logic fl, input logic [31:0] res,
                         input logic [31:0] d2, input logic [31:0] co, input logic [31:0] pc,
                         input logic [1:0] sel, input logic rwe, input logic mwe,
                         input logic [4:0] rd, input int lat);
        logic        memop;
        logic [31:0] a;
        exp_t        e;
        int          n;
        memop = v && (sel == 2'b01 || mwe);
        if (v && !fl) begin
            if (!memop) begin
                e.d   = (sel == 2'b10) ? pc + 32'd4 : (sel == 2'b11) ? co : res;
                e.rwe = rwe;
                e.rd  = rd;
                exp_q.push_back(e);
            end else begin
                a = res & ~32'h3;
                exp_addr = a; exp_we = mwe; exp_wdata = d2; cur_lat = lat;
                if (lat <= MW) begin
                    if (mwe) begin
                        ref_mem[a] = d2;
                        e.d = 32'h0; e.rwe = 1'b0;
                    end else begin
                        e.d = ref_mem.exists(a) ? ref_mem[a] : 32'h0; e.rwe = rwe;
                    end
                    e.rd = rd;
                    exp_q.push_back(e);
                end else begin
                    err_exp++;
                end
            end
        end
        valid_i = v; flush_i = fl; result_i = res; rd2_i = d2; cout_i = co; pc_i = pc;
        wb_sel_i = sel; rwe_i = rwe; mwe_i = mwe; rd_i = rd;
        @(posedge clk); #1;
        n = 0;
        while (stall && n < 300) begin
            valid_i = $urandom; flush_i = $urandom; result_i = $urandom; rd2_i = $urandom;
            wb_sel_i = 2'($urandom); mwe_i = $urandom; rd_i = 5'($urandom);
            @(posedge clk); #1;
            n++;
        end
        last_stall = n;
        if (v && !fl && memop) chk("stall_cycles", n, (lat <= MW) ? lat : MW);
        else                   chk("no_stall", n, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {mem_req, stall, valid_o, rwe_o, m_en, mem_err, mem_we}, 0);
        chk({tag, "_bus0"}, {wb_data, mem_addr}, 0);
        chk({tag, "_bus1"}, {mem_wdata, sel_o, m_dest}, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // Reset while a load is waiting for an ack
        valid_i = 1'b1; wb_sel_i = 2'b01; result_i = 32'h100; rd_i = 5'd3; rwe_i = 1'b1;
        exp_addr = 32'h100; exp_we = 1'b0; exp_wdata = rd2_i; cur_lat = 1000;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_before_rst", stall, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("rst_busy");
        rst = 1'b0;

        issue(1, 0, 32'h1234, 0, 0, 0, 2'b00, 1, 0, 5'd5, 1);
        chk("alu_passthru", {valid_o, wb_data, sel_o}, {1'b1, 32'h1234, 5'd5});
        issue(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 2'b10, 1, 0, 5'd7, 1);
        chk("pc4_wrap", {valid_o, wb_data}, {1'b1, 32'h0});
        issue(1, 0, 0, 0, 32'hBEEF_0001, 0, 2'b11, 1, 0, 5'd9, 1);

        ref_mem[32'h100] = 32'hCAFE_F00D;
        dev_mem[32'h100] = 32'hCAFE_F00D;
        issue(1, 0, 32'h103, 0, 0, 0, 2'b01, 1, 0, 5'd4, 3);
        chk("load_result", {valid_o, wb_data, rwe_o}, {1'b1, 32'hCAFE_F00D, 1'b1});

        issue(1, 0, 32'h40, 32'hA5A5_A5A5, 0, 0, 2'b00, 1, 1, 5'd6, 1);
        chk("store_result", {valid_o, rwe_o}, {1'b1, 1'b0});
        issue(1, 0, 32'h40, 0, 0, 0, 2'b01, 1, 0, 5'd8, 2);
        chk("store_readback", wb_data, 32'hA5A5_A5A5);

        issue(1, 1, 32'h80, 0, 0, 0, 2'b01, 1, 0, 5'd2, 1);
        chk("flush_idle", {mem_req, valid_o}, 0);

        issue(1, 0, 32'h44, 0, 0, 0, 2'b01, 1, 0, 5'd3, 9);
        chk("timeout_err", {mem_err, valid_o, stall}, {1'b1, 1'b0, 1'b0});
        issue(1, 0, 32'h55, 0, 0, 0, 2'b00, 1, 0, 5'd1, 1);
        chk("after_timeout", {valid_o, wb_data}, {1'b1, 32'h55});

        for (int i = 0; i < 300; i++) begin
            int lat;
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(MW + 1, MW + 3) : $urandom_range(1, MW);
            issue($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                  32'($urandom_range(0, 255)), $urandom, $urandom, $urandom,
                  2'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 5'($urandom), lat);
        end

        valid_i = 1'b0; flush_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        chk("err_drained", err_exp, 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
